// File: rtl/csm_requester.sv
// csm_requester: accepts one local read/write command at a time and forwards it to a
// shared memory through a request/grant/done handshake. It waits a bounded time for
// the grant and returns one response per command. It also counts the transactions that
// complete without error. The txn_load_i preload lets a test drive txn_count near its
// saturation point without running tens of thousands of transactions.
module csm_requester #(
  parameter int DATA_WIDTH = 8,
  parameter int ADD_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADD_WIDTH-1:0]  cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic [ADD_WIDTH-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_grant_i,
  input  logic                  mem_done_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic [15:0]           txn_count_o,
  input  logic                  txn_load_i,
  input  logic [15:0]           txn_load_value_i
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, RESP} state_e;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

  state_e                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADD_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [15:0]           txn_count_q, txn_count_d;

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Next-state logic: accept, wait for grant (bounded), wait for done, hold response.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    txn_count_d = txn_count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          mem_write_d = cmd_write_i;
          mem_addr_d  = cmd_addr_i;
          mem_wdata_d = cmd_wdata_i;
          wait_d      = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        // A grant always wins, even on the cycle that would otherwise time out.
        if (mem_grant_i && mem_done_i) begin
          rsp_rdata_d = mem_write_q ? '0 : mem_rdata_i;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else if (mem_grant_i) begin
          state_d = ACCESS;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_q + 8'd1 == TIMEOUT_W) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ACCESS: begin
        // Once granted the memory owns completion; there is no timeout here.
        if (mem_done_i) begin
          rsp_rdata_d = mem_write_q ? '0 : mem_rdata_i;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (!rsp_error_q && txn_count_q != 16'hFFFF) begin
            txn_count_d = txn_count_q + 16'd1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (txn_load_i) begin
      txn_count_d = txn_load_value_i;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign mem_req_o   = (state_q == REQ) || (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_error_o = rsp_error_q;
  assign txn_count_o = txn_count_q;

endmodule

// File: tb/tb_csm_requester.sv
// Testbench for csm_requester: directed scenarios followed by randomized transactions.
// Each transaction's expected latency and response are worked out from its grant and
// done delays with plain arithmetic.
module tb_csm_requester;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          mem_req;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_grant = 1'b0;
  logic          mem_done = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [15:0]   txn_count;
  logic          txn_load = 1'b0;
  logic [15:0]   txn_load_value = '0;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_count = '0;

  csm_requester #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .mem_req_o(mem_req), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_grant_i(mem_grant), .mem_done_i(mem_done),
    .mem_rdata_i(mem_rdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error), .txn_count_o(txn_count),
    .txn_load_i(txn_load), .txn_load_value_i(txn_load_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // g: REQ cycles before the grant (>= TO means never granted), d: cycles from grant
  // to done, r: cycles rsp_ready is held low, rd: read data returned by the memory.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int g, input int d, input int r, input logic [DW-1:0] rd);
    logic          exp_err;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    int            cyc;
    logic          ok;
    exp_err   = (g >= TO);
    exp_lat   = exp_err ? TO : 1 + g + d;
    exp_rdata = (exp_err || wr) ? '0 : rd;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
    cyc = 0;
    ok  = 1'b1;
    while (!rsp_valid && cyc < 60) begin
      if (!(mem_req === 1'b1 && mem_addr === addr && mem_wdata === wd &&
            mem_write === wr && cmd_ready === 1'b0)) ok = 1'b0;
      mem_grant = !exp_err && (cyc == g);
      mem_done  = !exp_err && (cyc == g + d);
      mem_rdata = mem_done ? rd : DW'($urandom);
      step();
      cyc++;
    end
    mem_grant = 1'b0; mem_done = 1'b0;
    check("mem_hold", {31'd0, ok}, 32'd1);
    check("latency", cyc, exp_lat);
    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
    check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err});
    check("mem_req_resp", {31'd0, mem_req}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < r; i++) begin
      cmd_valid = 1'b1; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
      mem_grant = 1'($urandom); mem_done = 1'($urandom); mem_rdata = DW'($urandom);
      if (!(rsp_valid === 1'b1 && rsp_rdata === exp_rdata && rsp_error === exp_err &&
            cmd_ready === 1'b0 && mem_req === 1'b0)) ok = 1'b0;
      step();
    end
    check("resp_hold", {31'd0, ok}, 32'd1);
    cmd_valid = 1'b0; mem_grant = 1'b0; mem_done = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (!exp_err && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    check("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("txn_count", {16'd0, txn_count}, {16'd0, exp_count});
  endtask

  task automatic check_reset_values(input string tag);
    logic ok;
    ok = (cmd_ready === 1'b1) && (mem_req === 1'b0) && (mem_write === 1'b0) &&
         (mem_addr === '0) && (mem_wdata === '0) && (rsp_valid === 1'b0) &&
         (rsp_rdata === '0) && (rsp_error === 1'b0) && (txn_count === 16'd0);
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    // Reset state
    #3;
    check_reset_values("reset_values");
    step(); step();
    rst_n = 1'b1;
    step();
    check_reset_values("after_release");

    // Minimum-latency read, then a delayed write
    do_txn(1'b0, 4'h3, 8'h00, 0, 0, 0, 8'hA5);
    do_txn(1'b1, 4'h7, 8'h3C, 3, 2, 0, 8'h99);
    // Timeout versus grant on the last allowed cycle
    do_txn(1'b0, 4'h2, 8'h11, TO, 0, 0, 8'h5A);
    do_txn(1'b0, 4'h9, 8'h22, TO - 1, 1, 0, 8'hC3);
    // Back-pressured response
    do_txn(1'b0, 4'hE, 8'h00, 1, 0, 5, 8'h6B);

    // Reset while in ACCESS abandons the transaction
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hB; cmd_wdata = 8'h77;
    step();
    cmd_valid = 1'b0;
    mem_grant = 1'b1;
    step();
    mem_grant = 1'b0;
    step();
    check("in_access", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_grant = 1'b1; mem_done = 1'b1; mem_rdata = 8'hEE;
    for (int i = 0; i < 3; i++) step();
    check("no_rsp_after_reset", {30'd0, rsp_valid, mem_req}, 32'd0);
    check("count_after_reset", {16'd0, txn_count}, 32'd0);
    mem_grant = 1'b0; mem_done = 1'b0;

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(17, 0)),
             int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), DW'($urandom));
    end

    // Counter saturation
    txn_load = 1'b1; txn_load_value = 16'hFFFE;
    step();
    txn_load = 1'b0;
    exp_count = 16'hFFFE;
    check("count_preload", {16'd0, txn_count}, {16'd0, exp_count});
    for (int t = 0; t < 3; t++) begin
      do_txn(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(2, 0)),
             int'($urandom_range(2, 0)), 0, DW'($urandom));
    end
    check("count_saturated", {16'd0, txn_count}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/csm_requester.md
CSM_REQUESTER -- requirements
Module: csm_requester

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the data word.
REQ-002 Parameter ADD_WIDTH, default 4, SHALL set the address width (1<<ADD_WIDTH locations).
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles to wait for grant (range 1..255).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  local command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_addr  input  ADD_WIDTH  target address.
REQ-010 cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 mem_req  output  1  request to the shared memory.
REQ-012 mem_write  output  1  registered copy of cmd_write.
REQ-013 mem_addr  output  ADD_WIDTH  registered address.
REQ-014 mem_wdata  output  DATA_WIDTH  registered write data.
REQ-015 mem_grant  input  1  memory arbiter grants this requester.
REQ-016 mem_done  input  1  access complete; mem_rdata valid this cycle.
REQ-017 mem_rdata  input  DATA_WIDTH  read data.
REQ-018 rsp_valid  output  1  response present.
REQ-019 rsp_ready  input  1  consumer accepts response.
REQ-020 rsp_rdata  output  DATA_WIDTH  read data (0 for writes and errors).
REQ-021 rsp_error  output  1  transaction aborted by timeout.
REQ-022 txn_count  output  16  count of successfully completed transactions.

Function
REQ-023 FSM states SHALL be IDLE, REQ, ACCESS, RESP.
REQ-024 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on cmd_valid&cmd_ready, capturing write/addr/wdata into mem_* registers, next state REQ.
REQ-025 mem_req SHALL be 1 in REQ and ACCESS only; mem_write/addr/wdata SHALL remain stable while mem_req=1.
REQ-026 In REQ: mem_grant&mem_done -> RESP (capture rdata); mem_grant only -> ACCESS; neither -> wait-counter increments.
REQ-027 Wait-counter SHALL clear on entry to REQ; when it reaches TIMEOUT without grant, next state RESP with rsp_error=1, rsp_rdata=0, mem_req deasserted.
REQ-028 Grant in the same cycle the counter reaches TIMEOUT SHALL take priority over timeout.
REQ-029 In ACCESS: mem_done -> RESP; otherwise remain (no timeout in ACCESS).
REQ-030 On read completion rsp_rdata SHALL equal mem_rdata sampled on the mem_done cycle; on write completion rsp_rdata=0; rsp_error=0.
REQ-031 In RESP, rsp_valid=1 and rsp_rdata/rsp_error stable until rsp_valid&rsp_ready, then next state IDLE.
REQ-032 txn_count SHALL increment at the RESP handshake when rsp_error=0, saturating at 16'hFFFF.
REQ-033 mem_done and mem_grant SHALL be ignored in IDLE and RESP.
REQ-034 Minimum latency: accept at cycle N, rsp_valid=1 at cycle N+2 (grant and done at N+1).
REQ-035 No new command SHALL be accepted until the prior response handshake completes (one outstanding transaction).

Reset
REQ-036 reset=0 SHALL immediately force IDLE, cmd_ready=1, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, txn_count=0, wait-counter=0.
REQ-037 Reset asserted mid-transaction SHALL abandon it with no response and no count change.

Verification
REQ-038 Read addr 4'h3, grant+done next cycle with mem_rdata=8'hA5 -> rsp_valid at N+2, rsp_rdata=8'hA5, rsp_error=0, txn_count=1.
REQ-039 Write addr 4'h7 data 8'h3C, grant after 3 cycles, done 2 cycles later -> mem_addr=7, mem_wdata=3C held throughout, rsp_rdata=0, txn_count+1.
REQ-040 No grant for 15 cycles -> rsp_error=1, rsp_rdata=0, mem_req=0, txn_count unchanged; grant on cycle 15 instead -> normal ACCESS.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, second cmd_valid not accepted until handshake.
REQ-042 reset=0 asserted in ACCESS -> all outputs at reset values asynchronously, no response after release.
REQ-043 Preload txn_count 16'hFFFE, complete 3 transactions -> txn_count saturates at 16'hFFFF.
